fifo_pop_stream: RTL

//   Reader end of the fifo_v2/fifo_v3 push/pop interface. Drains a non-fall-through FIFO via

---
 rtl/fifo_pop_stream.sv | 109 ++++++++++
 1 files changed

// File: rtl/fifo_pop_stream.sv
// fifo_pop_stream: drains a non-fall-through FIFO (empty/data/pop) into a registered
// valid/ready stream through a 2-entry skid buffer. The pop strobe depends only on the
// FIFO flag and the buffer occupancy, so there is no combinational ready -> pop path.
// Optional feature: define FIFO_POP_STREAM_STATS_EN to add the beats_o delivered-word counter.
module fifo_pop_stream #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o
`ifdef FIFO_POP_STREAM_STATS_EN
  ,
  output logic [31:0]           beats_o
`endif
);

  // Occupancy of the skid buffer
  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StTwo   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
  logic                  valid_q;
  logic                  deq;

  // Pop whenever there is room; deliberately blind to ready_i.
  assign fifo_pop_o = !rst_i && !flush_i && !fifo_empty_i && (state_q != StTwo);
  // A handshake during flush is discarded along with the buffer contents.
  assign deq        = valid_q && ready_i && !flush_i;
  assign valid_o    = valid_q;
  assign data_o     = slot0_q;

  // Next occupancy and slot contents from (pop, deq)
  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (flush_i) begin
      state_d = StEmpty;
      slot0_d = '0;
      slot1_d = '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (fifo_pop_o) begin
            state_d = StOne;
            slot0_d = fifo_data_i;
          end
        end
        StOne: begin
          if (fifo_pop_o && !deq) begin
            state_d = StTwo;
            slot1_d = fifo_data_i;
          end else if (fifo_pop_o && deq) begin
            slot0_d = fifo_data_i;
          end else if (deq) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (deq) begin
            state_d = StOne;
            slot0_d = slot1_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // State and slot registers; valid is a registered decode of the next occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      slot0_q <= '0;
      slot1_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      valid_q <= (state_d != StEmpty);
    end
  end

`ifdef FIFO_POP_STREAM_STATS_EN
  logic [31:0] beats_q;

  // Delivered-word counter; survives flush, wraps naturally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beats_q <= '0;
    end else if (deq) begin
      beats_q <= beats_q + 32'd1;
    end
  end

  assign beats_o = beats_q;
`endif

endmodule
